// File: rtl/uart_mmio_periph_pkg.sv
// uart_mmio_periph_pkg
//   Shared definitions for the memory-mapped UART: default bit period
//   (100 MHz / 115200 baud) and the state encoding used by both the
//   transmit and receive FSMs.
package uart_mmio_periph_pkg;

    localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_rx_deser.sv
// uart_rx_deser
//   Receive path: 2-flop synchronizer, 8N1 deserializer FSM and one-cycle
//   commit / frame-error strobes.
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   rxd            asynchronous serial input, idle high
//   rx_byte        assembled byte, stable from rx_commit until next frame
//   rx_commit      one-cycle pulse: good stop bit, rx_byte valid
//   rx_frame_err   one-cycle pulse: stop bit sampled low, byte dropped
module uart_rx_deser
    import uart_mmio_periph_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       rx_commit,
    output logic       rx_frame_err
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    // Start bit is checked CLKS_PER_BIT/2 cycles after detection; later
    // samples are spaced a full bit apart from there.
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    logic        rxd_meta;
    logic        rxd_sync;
    uart_state_t state;
    logic [15:0] cnt;
    logic [2:0]  idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta     <= 1'b1;
            rxd_sync     <= 1'b1;
            state        <= ST_IDLE;
            cnt          <= '0;
            idx          <= '0;
            rx_byte      <= '0;
            rx_commit    <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rxd_meta     <= rxd;
            rxd_sync     <= rxd_meta;
            rx_commit    <= 1'b0;
            rx_frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rxd_sync) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        idx <= '0;
                        // Line back high at mid-start: treat as a glitch.
                        state <= rxd_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        rx_byte <= {rxd_sync, rx_byte[7:1]};
                        if (idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                        if (rxd_sync) begin
                            rx_commit <= 1'b1;
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio_periph.sv
// uart_mmio_periph
//   8N1 UART for the core's MMIO window. Address decode lives in the core;
//   this block only sees the store/load strobes.
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   tx_data_in        byte to send, sampled with tx_we_in
//   tx_we_in          transmit strobe (ignored while tx_busy_out)
//   tx_busy_out       transmitter occupied (status bit 1)
//   rx_re_in          read acknowledge for the holding register
//   rx_data_out       receive holding register
//   rx_valid_out      holding register unread (status bit 0)
//   uart_txd          serial out, idle high
//   uart_rxd          serial in, asynchronous, idle high
//   rx_overrun_out    sticky: unread byte overwritten
//   rx_frame_err_out  one-cycle pulse: bad stop bit
module uart_mmio_periph
    import uart_mmio_periph_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data_in,
    input  logic       tx_we_in,
    output logic       tx_busy_out,
    input  logic       rx_re_in,
    output logic [7:0] rx_data_out,
    output logic       rx_valid_out,
    output logic       uart_txd,
    input  logic       uart_rxd,
    output logic       rx_overrun_out,
    output logic       rx_frame_err_out
);

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    uart_state_t tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_idx;
    logic [7:0]  tx_shift;

    logic [7:0]  rx_byte;
    logic        rx_commit;

    // uart_txd is registered and updated one state ahead so that each
    // state's line level appears on the first cycle of that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state    <= ST_IDLE;
            tx_cnt      <= '0;
            tx_idx      <= '0;
            tx_shift    <= '0;
            uart_txd    <= 1'b1;
            tx_busy_out <= 1'b0;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (tx_we_in) begin
                        tx_shift    <= tx_data_in;
                        tx_cnt      <= '0;
                        tx_state    <= ST_START;
                        uart_txd    <= 1'b0;
                        tx_busy_out <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        uart_txd <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_state <= ST_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_idx == 3'd7) begin
                            uart_txd <= 1'b1;
                            tx_state <= ST_STOP;
                        end else begin
                            tx_idx   <= tx_idx + 3'd1;
                            uart_txd <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt      <= '0;
                        tx_state    <= ST_IDLE;
                        tx_busy_out <= 1'b0;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    uart_rx_deser #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rxd          (uart_rxd),
        .rx_byte      (rx_byte),
        .rx_commit    (rx_commit),
        .rx_frame_err (rx_frame_err_out)
    );

    // A commit always wins over a read in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_out    <= '0;
            rx_valid_out   <= 1'b0;
            rx_overrun_out <= 1'b0;
        end else if (rx_commit) begin
            rx_data_out  <= rx_byte;
            rx_valid_out <= 1'b1;
            if (rx_valid_out && !rx_re_in) begin
                rx_overrun_out <= 1'b1;
            end
        end else if (rx_re_in) begin
            rx_valid_out <= 1'b0;
        end
    end

endmodule
